// File: rtl/gemm_pim_pkg.sv
// Shared types and default widths for the 32-input GEMM PIM tile scheduler.
package gemm_pim_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_e;

  localparam int PIM_W_DEF   = 18;
  localparam int ACC_W_DEF   = 24;
  localparam int ADC_LAT_DEF = 2;

endpackage

// File: rtl/gemm_pim_acc.sv
// Partial-sum accumulator for one weight row: load on the first K-tile, add afterwards.
// Overflow saturates when GEMM_PIM_SATURATE_EN is defined, otherwise wraps modulo 2^ACC_W.
module gemm_pim_acc
  import gemm_pim_pkg::*;
#(
  parameter int PIM_W = PIM_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             cap,
  input  logic             load,
  input  logic [PIM_W-1:0] din,
  output logic [ACC_W-1:0] acc
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] din_ext;
  logic [ACC_W-1:0] sum;

  assign din_ext = ACC_W'(din);

`ifdef GEMM_PIM_SATURATE_EN
  logic [ACC_W:0] sum_wide;
  assign sum_wide = {1'b0, acc_q} + {1'b0, din_ext};
  // A saturated value stays pinned: any further non-zero add carries out again.
  assign sum = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
`else
  assign sum = acc_q + din_ext;
`endif

  always_comb begin
    // NOTE: default first so every path assigns acc_d and no latch is inferred.
    acc_d = acc_q;
    if (clr)      acc_d = '0;
    else if (cap) acc_d = load ? din_ext : sum;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking for all state so flops update together at the edge.
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/gemm32_pim_sched.sv
// Row/K-tile sequencer for the 32-input GEMM PIM tile; issues compute strobes and returns row sums.
// Optional macro GEMM_PIM_SATURATE_EN (in gemm_pim_acc) selects saturating accumulation.
module gemm32_pim_sched
  import gemm_pim_pkg::*;
#(
  parameter int NUM_ROWS   = 32,
  parameter int MAX_KTILES = 8,
  parameter int ADC_LAT    = ADC_LAT_DEF,
  parameter int PIM_W      = PIM_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  localparam int RW        = $clog2(NUM_ROWS),
  localparam int KW        = $clog2(MAX_KTILES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [RW:0]      cfg_rows,
  input  logic [KW:0]      cfg_ktiles,
  output logic             busy,
  output logic             done,
  output logic [RW-1:0]    pim_add,
  output logic [KW-1:0]    pim_ktile,
  output logic             pim_en,
  input  logic [PIM_W-1:0] pim_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_data,
  output logic [RW-1:0]    res_row
);

  localparam logic [3:0] ADC_LAT_C = 4'(ADC_LAT);

  state_e        state_q, state_d;
  logic [RW:0]   rows_q, rows_d;
  logic [KW:0]   kt_q, kt_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          acc_clr, acc_cap;
  logic [RW:0]   row_nxt;
  logic [KW:0]   k_nxt;

  assign row_nxt = {1'b0, row_q} + (RW+1)'(1);
  assign k_nxt   = {1'b0, k_q} + (KW+1)'(1);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    kt_d    = kt_q;
    row_d   = row_q;
    k_d     = k_q;
    wcnt_d  = wcnt_q;
    acc_clr = 1'b0;
    acc_cap = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d  = cfg_rows;
          kt_d    = cfg_ktiles;
          row_d   = '0;
          k_d     = '0;
          acc_clr = 1'b1;
          state_d = (cfg_rows == '0 || cfg_ktiles == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = ADC_LAT_C;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        // The tile output is valid only on the last cycle of the ADC window.
        if (wcnt_q == 4'd1) begin
          acc_cap = 1'b1;
          if (k_nxt < kt_q) begin
            k_d     = k_nxt[KW-1:0];
            state_d = S_ISSUE;
          end else begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (res_ready) begin
          if (row_nxt < rows_q) begin
            row_d   = row_nxt[RW-1:0];
            k_d     = '0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      kt_q    <= '0;
      row_q   <= '0;
      k_q     <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      kt_q    <= kt_d;
      row_q   <= row_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
    end
  end

  gemm_pim_acc #(
    .PIM_W (PIM_W),
    .ACC_W (ACC_W)
  ) u_acc (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .cap   (acc_cap),
    .load  (k_q == '0),
    .din   (pim_data),
    .acc   (res_data)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign pim_en    = (state_q == S_ISSUE);
  assign res_valid = (state_q == S_OUT);
  assign pim_add   = row_q;
  assign pim_ktile = k_q;
  assign res_row   = row_q;

endmodule

// File: tb/tb_gemm32_pim_sched.sv
// Directed bench for gemm32_pim_sched; a second instance with ACC_W=18 covers overflow.
module tb_gemm32_pim_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  cfg_rows;
  logic [3:0]  cfg_ktiles;
  logic [17:0] pim_data;
  logic        res_ready;

  logic        busy, done, pim_en, res_valid;
  logic [4:0]  pim_add, res_row;
  logic [2:0]  pim_ktile;
  logic [23:0] res_data;

  logic        busy18, done18, pim_en18, res_valid18;
  logic [4:0]  pim_add18, res_row18;
  logic [2:0]  pim_ktile18;
  logic [17:0] res_data18;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gemm32_pim_sched dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
    .busy(busy), .done(done), .pim_add(pim_add), .pim_ktile(pim_ktile), .pim_en(pim_en),
    .pim_data(pim_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row)
  );

  gemm32_pim_sched #(.ACC_W(18)) dut18 (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_ktiles(cfg_ktiles),
    .busy(busy18), .done(done18), .pim_add(pim_add18), .pim_ktile(pim_ktile18), .pim_en(pim_en18),
    .pim_data(pim_data), .res_valid(res_valid18), .res_ready(res_ready),
    .res_data(res_data18), .res_row(res_row18)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to 1 time unit after the next rising edge: inputs are driven and outputs sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_done"},      32'(done),      32'd0);
    check({tag, "_pim_en"},    32'(pim_en),    32'd0);
    check({tag, "_pim_add"},   32'(pim_add),   32'd0);
    check({tag, "_pim_ktile"}, 32'(pim_ktile), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_data"},  32'(res_data),  32'd0);
    check({tag, "_res_row"},   32'(res_row),   32'd0);
  endtask

  logic [4:0] add_log [8];
  logic [2:0] kt_log  [8];
  int         n_issue;
  int         n_res;
  int         guard;
  logic [23:0] held_data;
  `ifdef GEMM_PIM_SATURATE_EN
  localparam logic [31:0] EXP18 = 32'd262143;
  `else
  localparam logic [31:0] EXP18 = 32'd262142;
  `endif

  initial begin
    reset = 1'b1; start = 1'b0; cfg_rows = '0; cfg_ktiles = '0;
    pim_data = '0; res_ready = 1'b0;
    step(); step();
    check_idle_outputs("rst");
    reset = 1'b0;
    step();

    // 1) one row, one K-tile, data 100
    pim_data = 18'd100; res_ready = 1'b1; cfg_rows = 6'd1; cfg_ktiles = 4'd1; start = 1'b1;
    step();  // cycle 1
    start = 1'b0; cfg_rows = 6'd7;
    check("t1_c1_pim_en", 32'(pim_en), 32'd1);
    check("t1_c1_busy",   32'(busy),   32'd1);
    check("t1_c1_add",    32'(pim_add), 32'd0);
    step();  // cycle 2
    check("t1_c2_pim_en", 32'(pim_en), 32'd0);
    step();  // cycle 3
    check("t1_c3_valid",  32'(res_valid), 32'd0);
    step();  // cycle 4
    check("t1_c4_valid",  32'(res_valid), 32'd1);
    check("t1_c4_data",   32'(res_data),  32'd100);
    check("t1_c4_row",    32'(res_row),   32'd0);
    step();  // cycle 5
    check("t1_c5_done",   32'(done),      32'd1);
    check("t1_c5_valid",  32'(res_valid), 32'd0);
    check("t1_c5_busy",   32'(busy),      32'd1);
    step();  // cycle 6
    check("t1_c6_done",   32'(done), 32'd0);
    check("t1_c6_busy",   32'(busy), 32'd0);

    // 2) two rows, three K-tiles, data 10/20/30 by K-tile
    cfg_rows = 6'd2; cfg_ktiles = 4'd3; start = 1'b1;
    n_issue = 0; n_res = 0; guard = 0;
    step();
    start = 1'b0;
    while (!done && guard < 60) begin
      pim_data = 18'(10 * (int'(pim_ktile) + 1));
      if (pim_en) begin
        if (n_issue < 8) begin
          add_log[n_issue] = pim_add;
          kt_log[n_issue]  = pim_ktile;
        end
        n_issue++;
      end
      if (res_valid) begin
        check("t2_res_data", 32'(res_data), 32'd60);
        check("t2_res_row",  32'(res_row),  32'(n_res));
        n_res++;
      end
      step();
      guard++;
    end
    check("t2_done_seen", 32'(done),    32'd1);
    check("t2_n_issue",   32'(n_issue), 32'd6);
    check("t2_n_res",     32'(n_res),   32'd2);
    for (int i = 0; i < 6; i++) begin
      check("t2_ktile_seq", 32'(kt_log[i]),  32'(i % 3));
      check("t2_add_seq",   32'(add_log[i]), 32'(i / 3));
    end
    step();

    // 3) consumer stalls for 5 cycles in OUT; a start pulse mid-job is ignored
    cfg_rows = 6'd2; cfg_ktiles = 4'd1; pim_data = 18'd7; res_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!res_valid && guard < 20) begin step(); guard++; end
    check("t3_valid_seen", 32'(res_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      cfg_rows = 6'd0;
      check("t3_stall_valid",  32'(res_valid), 32'd1);
      check("t3_stall_data",   32'(res_data),  32'd7);
      check("t3_stall_row",    32'(res_row),   32'd0);
      check("t3_stall_pim_en", 32'(pim_en),    32'd0);
      step();
    end
    start = 1'b0;
    check("t3_still_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    step();
    check("t3_next_issue", 32'(pim_en),  32'd1);
    check("t3_next_add",   32'(pim_add), 32'd1);
    guard = 0;
    while (!res_valid && guard < 20) begin step(); guard++; end
    check("t3_row1_row",  32'(res_row),  32'd1);
    check("t3_row1_data", 32'(res_data), 32'd7);
    step();
    check("t3_done", 32'(done), 32'd1);
    step();

    // 4) overflow: two full-scale captures
    cfg_rows = 6'd1; cfg_ktiles = 4'd2; pim_data = 18'h3FFFF; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!res_valid && guard < 20) begin step(); guard++; end
    check("t4_valid18",  32'(res_valid18), 32'd1);
    check("t4_data18",   32'(res_data18),  EXP18);
    check("t4_data24",   32'(res_data),    32'd524286);
    step();
    check("t4_done", 32'(done), 32'd1);
    step();

    // 5) zero-row job, with start re-pulsed while busy
    cfg_rows = 6'd0; cfg_ktiles = 4'd3; start = 1'b1;
    step();  // cycle 1
    check("t5_c1_done",   32'(done),      32'd1);
    check("t5_c1_pim_en", 32'(pim_en),    32'd0);
    check("t5_c1_valid",  32'(res_valid), 32'd0);
    cfg_rows = 6'd1;
    step();  // cycle 2: start was seen only in DONE
    start = 1'b0;
    check("t5_c2_busy", 32'(busy), 32'd0);
    check("t5_c2_done", 32'(done), 32'd0);
    step();
    check("t5_c3_busy",   32'(busy),   32'd0);
    check("t5_c3_pim_en", 32'(pim_en), 32'd0);

    // 6) reset during WAIT of row 1, then a clean restart
    cfg_rows = 6'd2; cfg_ktiles = 4'd1; pim_data = 18'd5; res_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (!(pim_en && pim_add == 5'd1) && guard < 20) begin step(); guard++; end
    check("t6_row1_issue", 32'(pim_en), 32'd1);
    step();  // first WAIT cycle of row 1
    reset = 1'b1;
    step();
    check_idle_outputs("t6_rst");
    reset = 1'b0;
    held_data = res_data;
    step();
    check("t6_no_done", 32'(done), 32'd0);
    check("t6_held",    32'(res_data), 32'(held_data));
    pim_data = 18'd9; cfg_rows = 6'd1; start = 1'b1;
    step();  // cycle 1
    start = 1'b0;
    check("t6_c1_pim_en", 32'(pim_en),  32'd1);
    check("t6_c1_add",    32'(pim_add), 32'd0);
    step(); step(); step();  // cycle 4
    check("t6_c4_valid", 32'(res_valid), 32'd1);
    check("t6_c4_data",  32'(res_data),  32'd9);
    check("t6_c4_row",   32'(res_row),   32'd0);
    step();
    check("t6_c5_done", 32'(done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
